// File: rtl/coco_kbd_pkg.sv
// Shared receiver state type, scancode constants and the PS/2 set-2 to CoCo matrix map.
// Latency: none (types and a purely combinational lookup function).
// Backpressure: not applicable.
package coco_kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] BRK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX = 8'hE0;
    localparam logic [7:0] BAT_OK     = 8'hAA;

    localparam int unsigned MAT_ROWS = 7;
    localparam int unsigned MAT_COLS = 8;

    // Keyboard matrix image: bit [r][c] set means key at row r / column c is down.
    typedef logic [MAT_ROWS-1:0][MAT_COLS-1:0] kbd_mat_t;

    // Result of a scancode lookup.
    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic key_pos_t kp(input logic [2:0] row, input logic [2:0] col);
        key_pos_t p;
        p.valid = 1'b1;
        p.row   = row;
        p.col   = col;
        return p;
    endfunction

    // Map {extended, scancode} to a matrix position; valid=0 for keys the CoCo lacks.
    function automatic key_pos_t key_lookup(input logic ext, input logic [7:0] code);
        key_pos_t p;
        p = '0;
        case ({ext, code})
            // row 0: @ A B C D E F G  ('[' stands in for @)
            9'h054: p = kp(3'd0, 3'd0);
            9'h01C: p = kp(3'd0, 3'd1);
            9'h032: p = kp(3'd0, 3'd2);
            9'h021: p = kp(3'd0, 3'd3);
            9'h023: p = kp(3'd0, 3'd4);
            9'h024: p = kp(3'd0, 3'd5);
            9'h02B: p = kp(3'd0, 3'd6);
            9'h034: p = kp(3'd0, 3'd7);
            // row 1: H I J K L M N O
            9'h033: p = kp(3'd1, 3'd0);
            9'h043: p = kp(3'd1, 3'd1);
            9'h03B: p = kp(3'd1, 3'd2);
            9'h042: p = kp(3'd1, 3'd3);
            9'h04B: p = kp(3'd1, 3'd4);
            9'h03A: p = kp(3'd1, 3'd5);
            9'h031: p = kp(3'd1, 3'd6);
            9'h044: p = kp(3'd1, 3'd7);
            // row 2: P Q R S T U V W
            9'h04D: p = kp(3'd2, 3'd0);
            9'h015: p = kp(3'd2, 3'd1);
            9'h02D: p = kp(3'd2, 3'd2);
            9'h01B: p = kp(3'd2, 3'd3);
            9'h02C: p = kp(3'd2, 3'd4);
            9'h03C: p = kp(3'd2, 3'd5);
            9'h02A: p = kp(3'd2, 3'd6);
            9'h01D: p = kp(3'd2, 3'd7);
            // row 3: X Y Z UP DOWN LEFT RIGHT SPACE
            9'h022: p = kp(3'd3, 3'd0);
            9'h035: p = kp(3'd3, 3'd1);
            9'h01A: p = kp(3'd3, 3'd2);
            9'h175: p = kp(3'd3, 3'd3);
            9'h172: p = kp(3'd3, 3'd4);
            9'h16B: p = kp(3'd3, 3'd5);
            9'h174: p = kp(3'd3, 3'd6);
            9'h029: p = kp(3'd3, 3'd7);
            // row 4: 0 1 2 3 4 5 6 7
            9'h045: p = kp(3'd4, 3'd0);
            9'h016: p = kp(3'd4, 3'd1);
            9'h01E: p = kp(3'd4, 3'd2);
            9'h026: p = kp(3'd4, 3'd3);
            9'h025: p = kp(3'd4, 3'd4);
            9'h02E: p = kp(3'd4, 3'd5);
            9'h036: p = kp(3'd4, 3'd6);
            9'h03D: p = kp(3'd4, 3'd7);
            // row 5: 8 9 : ; , - . /  (apostrophe stands in for :)
            9'h03E: p = kp(3'd5, 3'd0);
            9'h046: p = kp(3'd5, 3'd1);
            9'h052: p = kp(3'd5, 3'd2);
            9'h04C: p = kp(3'd5, 3'd3);
            9'h041: p = kp(3'd5, 3'd4);
            9'h04E: p = kp(3'd5, 3'd5);
            9'h049: p = kp(3'd5, 3'd6);
            9'h04A: p = kp(3'd5, 3'd7);
            // row 6: ENTER CLEAR(Home) BREAK(Esc) ALT CTRL F1 F2 SHIFT
            9'h05A, 9'h15A: p = kp(3'd6, 3'd0);
            9'h16C:         p = kp(3'd6, 3'd1);
            9'h076:         p = kp(3'd6, 3'd2);
            9'h011, 9'h111: p = kp(3'd6, 3'd3);
            9'h014, 9'h114: p = kp(3'd6, 3'd4);
            9'h005:         p = kp(3'd6, 3'd5);
            9'h006:         p = kp(3'd6, 3'd6);
            9'h012, 9'h059: p = kp(3'd6, 3'd7);
            default:        p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronizers, 11-bit frame FSM, odd parity, optional watchdog (PS2_WATCHDOG_EN).
// Latency: byte_vld_o/err_o pulse combinationally in the cycle the stop/parity bit is sampled, 3 clk after a ps2_clk fall.
// Backpressure: none; the keyboard cannot be stalled, so each byte is offered for exactly one cycle.
module ps2_rx_frame
    import coco_kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 57_000_000,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       err_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    rx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       par_q, par_d;
    logic       fall;
    logic       dat_s;
    logic       timeout;

    assign fall  = clk_prev_q & ~clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Two-flop synchronizers plus a delayed copy of the clock for falling-edge detection.
    // Reset to the idle-bus level (high) so leaving reset never looks like an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    // Frame FSM state, shift register, bit counter and running parity.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
        end
    end

`ifdef PS2_WATCHDOG_EN
    localparam int unsigned     WD_LIMIT = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int unsigned     WD_W     = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(WD_LIMIT);

    logic [WD_W-1:0] wd_cnt_q;

    // Clk cycles since the last PS/2 clock fall; held at zero while idle, saturates at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (fall || (state_q == ST_IDLE)) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end
    end

    // The FSM drops to IDLE on expiry, which clears the counter, so this fires for one cycle only.
    assign timeout = (state_q != ST_IDLE) && (wd_cnt_q == WD_MAX);
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic: advance only on a detected PS/2 clock fall; parity accumulates over data bits.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        byte_vld_o = 1'b0;
        err_o      = 1'b0;
        if (timeout) begin
            state_d = ST_IDLE;
            err_o   = 1'b1;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    par_d     = par_q ^ dat_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    // Odd parity: data bits XOR parity bit must be 1.
                    if (par_q ^ dat_s) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_IDLE;
                        err_o   = 1'b1;
                    end
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_s) begin
                        byte_vld_o = 1'b1;
                    end else begin
                        err_o = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/ps2_coco_matrix.sv
// PS/2 keyboard to CoCo PIA0 key matrix: decodes set-2 make/break/extended codes into a 7x8 matrix (watchdog via PS2_WATCHDOG_EN).
// Latency: ROW_N reflects a key 2 clk after the stop bit is sampled (decode register, then matrix register).
// Backpressure: none; every received byte is decoded, and ROW_N follows COL_N combinationally.
module ps2_coco_matrix
    import coco_kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 57_000_000,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       COCO_RESET_N,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] COL_N,
    output logic [6:0] ROW_N,
    output logic       KEY_EVT,
    output logic       FRAME_ERR
);

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_err;

    ps2_rx_frame #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk_i      (clk),
        .rst_ni     (COCO_RESET_N),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .err_o      (rx_err)
    );

    key_pos_t   lk;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       dec_vld_q, dec_vld_d;
    logic       dec_clr_q, dec_clr_d;
    logic       dec_make_q, dec_make_d;
    logic [2:0] dec_row_q, dec_row_d;
    logic [2:0] dec_col_q, dec_col_d;
    logic       ferr_q;
    kbd_mat_t   mat_q, mat_d;
    logic       evt_q, evt_d;

    assign lk = key_lookup(ext_q, rx_byte);

    // Decode stage: prefixes only set flags; any other byte consumes both flags.
    always_comb begin
        brk_d      = brk_q;
        ext_d      = ext_q;
        dec_vld_d  = 1'b0;
        dec_clr_d  = 1'b0;
        dec_make_d = ~brk_q;
        dec_row_d  = lk.row;
        dec_col_d  = lk.col;
        if (rx_vld) begin
            if (rx_byte == BRK_PREFIX) begin
                brk_d = 1'b1;
            end else if (rx_byte == EXT_PREFIX) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (rx_byte == BAT_OK) begin
                    dec_clr_d = 1'b1;
                end else if (lk.valid) begin
                    dec_vld_d = 1'b1;
                end
            end
        end
    end

    // Decode register, prefix flags and the registered frame-error pulse.
    always_ff @(posedge clk or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            dec_vld_q  <= 1'b0;
            dec_clr_q  <= 1'b0;
            dec_make_q <= 1'b0;
            dec_row_q  <= '0;
            dec_col_q  <= '0;
            ferr_q     <= 1'b0;
        end else begin
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            dec_vld_q  <= dec_vld_d;
            dec_clr_q  <= dec_clr_d;
            dec_make_q <= dec_make_d;
            dec_row_q  <= dec_row_d;
            dec_col_q  <= dec_col_d;
            ferr_q     <= rx_err;
        end
    end

    // Matrix update; KEY_EVT only when a bit actually changes, so repeats are silent.
    always_comb begin
        mat_d = mat_q;
        evt_d = 1'b0;
        if (dec_clr_q) begin
            mat_d = '0;
            evt_d = |mat_q;
        end else if (dec_vld_q) begin
            mat_d[dec_row_q][dec_col_q] = dec_make_q;
            evt_d = (mat_q[dec_row_q][dec_col_q] != dec_make_q);
        end
    end

    // Matrix register and key-event pulse.
    always_ff @(posedge clk or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            mat_q <= '0;
            evt_q <= 1'b0;
        end else begin
            mat_q <= mat_d;
            evt_q <= evt_d;
        end
    end

    // Row returns: a row is pulled low when any held key in it sits on a strobed (low) column.
    always_comb begin
        ROW_N = '1;
        for (int r = 0; r < 7; r++) begin
            ROW_N[r] = ~|(mat_q[r] & ~COL_N);
        end
    end

    assign KEY_EVT   = evt_q;
    assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_ps2_coco_matrix.sv
// Self-checking bench for ps2_coco_matrix: directed PS/2 frames, a key-matrix model and per-cycle output comparison.
// Latency: model applies a decoded byte 4 posedges after the stop-bit fall is driven (2 sync + edge detect + 2 stages).
// Backpressure: none.
module tb_ps2_coco_matrix;

    logic       clk = 1'b0;
    logic       COCO_RESET_N;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] COL_N;
    logic [6:0] ROW_N;
    logic       KEY_EVT;
    logic       FRAME_ERR;

    ps2_coco_matrix #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (200)
    ) dut (
        .clk          (clk),
        .COCO_RESET_N (COCO_RESET_N),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .COL_N        (COL_N),
        .ROW_N        (ROW_N),
        .KEY_EVT      (KEY_EVT),
        .FRAME_ERR    (FRAME_ERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Key map as the keyboard layout table: entry [row][col] = {extended, scancode}.
    localparam logic [8:0] KMAP [7][8] = '{
        '{9'h054, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034},
        '{9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044},
        '{9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D},
        '{9'h022, 9'h035, 9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174, 9'h029},
        '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D},
        '{9'h03E, 9'h046, 9'h052, 9'h04C, 9'h041, 9'h04E, 9'h049, 9'h04A},
        '{9'h05A, 9'h16C, 9'h076, 9'h011, 9'h014, 9'h005, 9'h006, 9'h012}
    };
    // Second keys sharing a position: RShift, keypad Enter, right Alt, right Ctrl.
    localparam logic [8:0] ALT_K [4] = '{9'h059, 9'h15A, 9'h111, 9'h114};
    localparam int         ALT_R [4] = '{6, 6, 6, 6};
    localparam int         ALT_C [4] = '{7, 0, 3, 4};

    bit   mdl [7][8];
    logic mdl_brk, mdl_ext;

    int n_checks = 0, n_errs = 0;
    int evt_seen = 0, err_seen = 0, wd_seen = 0;
    logic wd_window = 1'b0;

    // Frame handoff from the stimulus to the model.
    int         sched_id = 0, sched_done = 0, sched_cyc = 0;
    logic [7:0] sched_byte = 8'h00;
    logic       sched_err = 1'b0;

    // Literal expectation requests from the stimulus.
    int          lit_id = 0, lit_done = 0, lit_sel = 0;
    logic [31:0] lit_exp = '0;
    string       lit_name = "";

    function automatic bit mdl_find(input logic [8:0] k, output int r, output int c);
        r = 0;
        c = 0;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 8; j++)
                if (KMAP[i][j] == k) begin r = i; c = j; return 1'b1; end
        for (int i = 0; i < 4; i++)
            if (ALT_K[i] == k) begin r = ALT_R[i]; c = ALT_C[i]; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [6:0] mdl_rows(input logic [7:0] col_n);
        logic [6:0] rn;
        rn = '1;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 8; c++)
                if (mdl[r][c] && !col_n[c]) rn[r] = 1'b0;
        return rn;
    endfunction

    task automatic mdl_clear();
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 8; c++) mdl[r][c] = 1'b0;
    endtask

    task automatic mdl_byte(input logic [7:0] b, output logic evt);
        int r, c;
        bit any;
        evt = 1'b0;
        if (b == 8'hF0) mdl_brk = 1'b1;
        else if (b == 8'hE0) mdl_ext = 1'b1;
        else begin
            if (b == 8'hAA) begin
                any = 1'b0;
                for (int i = 0; i < 7; i++)
                    for (int j = 0; j < 8; j++) any |= mdl[i][j];
                evt = any;
                mdl_clear();
            end else if (mdl_find({mdl_ext, b}, r, c)) begin
                evt = (mdl[r][c] != !mdl_brk);
                mdl[r][c] = !mdl_brk;
            end
            mdl_brk = 1'b0;
            mdl_ext = 1'b0;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Compare process: advance the model and check every output each cycle.
    always @(negedge clk) begin
        logic       exp_evt, exp_err;
        logic [31:0] got_lit;
        exp_evt = 1'b0;
        exp_err = 1'b0;
        if (!COCO_RESET_N) begin
            mdl_clear();
            mdl_brk = 1'b0;
            mdl_ext = 1'b0;
            sched_done = sched_id;
        end else if (sched_id != sched_done) begin
            if (sched_err && cyc == sched_cyc + 3) begin
                exp_err = 1'b1;
                sched_done = sched_id;
            end else if (!sched_err && cyc == sched_cyc + 4) begin
                mdl_byte(sched_byte, exp_evt);
                sched_done = sched_id;
            end
        end
        if (KEY_EVT === 1'b1) evt_seen++;
        if (FRAME_ERR === 1'b1) err_seen++;
        check("row_n", 32'(ROW_N), 32'(mdl_rows(COL_N)));
        check("key_evt", 32'(KEY_EVT), 32'(exp_evt));
        if (wd_window) begin
            if (FRAME_ERR === 1'b1) wd_seen++;
        end else begin
            check("frame_err", 32'(FRAME_ERR), 32'(exp_err));
        end
        if (lit_id != lit_done) begin
            case (lit_sel)
                0:       got_lit = 32'(ROW_N);
                1:       got_lit = 32'(wd_seen);
                2:       got_lit = 32'(err_seen);
                default: got_lit = 32'(evt_seen);
            endcase
            check(lit_name, got_lit, lit_exp);
            lit_done = lit_id;
        end
    end

    // sel: 0 ROW_N, 1 watchdog pulses, 2 FRAME_ERR pulses, 3 KEY_EVT pulses.
    task automatic lit(input int sel, input logic [31:0] exp, input string nm);
        lit_sel  = sel;
        lit_exp  = exp;
        lit_name = nm;
        lit_id++;
        @(negedge clk);
        #1;
    endtask

    // Drive the first nbits bits of a frame; half bit period of 10 clk cycles.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            ps2_data = bits[i];
            repeat (10) @(posedge clk);
            #1;
            ps2_clk = 1'b0;
            if ((i == 9 && bad_par) || (i == 10 && !bad_par)) begin
                sched_cyc  = cyc;
                sched_byte = b;
                sched_err  = bad_par | bad_stop;
                sched_id++;
            end
            repeat (10) @(posedge clk);
            #1;
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    initial begin
        COCO_RESET_N = 1'b0;
        ps2_clk      = 1'b1;
        ps2_data     = 1'b1;
        COL_N        = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        lit(0, 32'h7F, "reset_row_n");
        COCO_RESET_N = 1'b1;
        repeat (4) @(posedge clk);

        COL_N = 8'hFD;
        send(8'h1C);               lit(0, 32'h7E, "a_make");
        lit(3, 32'd1, "a_make_evt");
        send(8'h1C);               lit(3, 32'd1, "a_make_repeat_silent");
        send(8'hF0); send(8'h1C);  lit(0, 32'h7F, "a_break");
        lit(3, 32'd2, "a_break_evt");
        send(8'hF0); send(8'h32);  lit(3, 32'd2, "break_unheld_silent");

        COL_N = 8'hF7;
        send(8'hE0); send(8'h75);  lit(0, 32'h77, "up_make");
        COL_N = 8'hFD;
        send(8'hF0); send(8'h00); send(8'h1C);
        lit(0, 32'h7E, "flags_clear_after_miss");
        send(8'hE0); send(8'h1C);  lit(0, 32'h7E, "ext_miss_no_change");
        lit(3, 32'd4, "evt_count_keys");
        COL_N = 8'hF5;             lit(0, 32'h76, "two_keys_held");
        COL_N = 8'hFD;
        send(8'hF0); send(8'h1C);  lit(0, 32'h7F, "a_break_again");

        send_frame(8'h1C, 1'b1, 1'b0, 11);
        lit(0, 32'h7F, "bad_parity_row");
        lit(2, 32'd1, "bad_parity_err");
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        lit(0, 32'h7F, "bad_stop_row");
        lit(2, 32'd2, "bad_stop_err");

        COL_N = 8'h7F;
        send(8'h12); send(8'h59);  lit(0, 32'h3F, "both_shifts");
        send(8'hF0); send(8'h59);  lit(0, 32'h7F, "rshift_break_clears");
        COL_N = 8'h00;             lit(0, 32'h77, "all_cols_up_held");
        send(8'hAA);               lit(0, 32'h7F, "bat_clears");
        lit(3, 32'd8, "evt_count_bat");

        COL_N = 8'hFD;
        send(8'h1C);               lit(0, 32'h7E, "a_held");
`ifdef PS2_WATCHDOG_EN
        send_frame(8'h5A, 1'b0, 1'b0, 5);
        wd_window = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        wd_window = 1'b0;
        lit(1, 32'd1, "watchdog_err_once");
        COL_N = 8'hFE;
        send(8'h5A);               lit(0, 32'h3F, "enter_after_timeout");
        COL_N = 8'hFD;             lit(0, 32'h7E, "a_still_held");
        send_frame(8'h33, 1'b0, 1'b0, 5);
`else
        send_frame(8'h5A, 1'b0, 1'b0, 5);
        repeat (400) @(posedge clk);
        #1;
        lit(2, 32'd2, "stall_no_err");
        lit(0, 32'h7E, "a_still_held");
`endif
        #1;
        COCO_RESET_N = 1'b0;
        lit(0, 32'h7F, "reset_mid_frame_row");
        repeat (3) @(posedge clk);
        #1;
        COCO_RESET_N = 1'b1;
        repeat (3) @(posedge clk);
        send(8'h1C);               lit(0, 32'h7E, "a_after_reset");
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ps2_coco_matrix.md
PS2_COCO_MATRIX -- requirements
Module: ps2_coco_matrix

Interface
REQ-001 SHALL expose parameter CLK_HZ, default 57_000_000, the clk frequency used to derive the watchdog count.
REQ-002 SHALL expose parameter TIMEOUT_US, default 200, the maximum allowed gap between PS/2 clock falling edges inside one frame.
REQ-003 SHALL have port clk, input, 1, the single system clock (CLK_57 domain).
REQ-004 SHALL have port COCO_RESET_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1, PS/2 keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1, PS/2 keyboard data, asynchronous to clk.
REQ-007 SHALL have port COL_N, input, 8, PIA0 port-B column strobes, active low.
REQ-008 SHALL have port ROW_N, output, 7, PIA0 port-A row returns, active low.
REQ-009 SHALL have port KEY_EVT, output, 1, a one-cycle pulse on every matrix bit change.
REQ-010 SHALL have port FRAME_ERR, output, 1, a one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized clock.
REQ-012 Receiver FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL advance only on a detected falling edge.
REQ-013 In IDLE, data=0 SHALL go to DATA; data=1 SHALL stay in IDLE.
REQ-014 DATA SHALL shift in 8 bits LSB-first and go to PARITY.
REQ-015 PARITY SHALL check for odd parity over data and parity bits.
REQ-016 STOP SHALL require data=1, then return to IDLE.
REQ-017 A parity fail or stop=0 SHALL discard the byte, pulse FRAME_ERR and return to IDLE.
REQ-018 The decoder SHALL treat byte 0xF0 as setting a break flag and byte 0xE0 as setting an extended flag.
REQ-019 For any other byte, the decoder SHALL look up (ext, code) and, on a hit, set (make) or clear (break) matrix[row][col].
REQ-020 Both flags SHALL clear after any non-prefix byte, whether or not the lookup hits.
REQ-021 A lookup miss SHALL leave the matrix unchanged, with no KEY_EVT.
REQ-022 Byte 0xAA (keyboard BAT) SHALL clear the whole matrix.
REQ-023 Latency: the matrix change SHALL be visible on ROW_N exactly 2 clk cycles after the cycle the stop bit is sampled (1 cycle for the decode register, 1 for the matrix register).
REQ-024 ROW_N[r] SHALL equal NOT(OR over c of matrix[r][c] AND NOT COL_N[c]), purely combinational from the matrix register.
REQ-025 With COL_N = 0xFF, ROW_N SHALL be 0x7F.
REQ-026 Make of a key already set and break of a key already clear SHALL be idempotent, with no KEY_EVT.
REQ-027 Multiple simultaneous keys SHALL be held independently (no rollover limit).
REQ-028 Matrix map (row: cols 0-7):
- row 0: @ A B C D E F G
- row 1: H-O
- row 2: P-W
- row 3: X Y Z UP DOWN LEFT RIGHT SPACE
- row 4: 0-7
- row 5: 8 9 : ; , - . /
- row 6: ENTER CLEAR BREAK ALT CTRL F1 F2 SHIFT
REQ-029 Left and right Shift SHALL both map to row 6 col 7, and either break SHALL clear it.

Reset
REQ-030 Asserting COCO_RESET_N low SHALL asynchronously force: FSM to IDLE, shift register 0, both flags clear, matrix all 0, ROW_N 0x7F, KEY_EVT 0, FRAME_ERR 0.
REQ-031 On reset mid-frame, the partial byte SHALL be lost, and the next start bit SHALL be decoded normally.

Configuration
REQ-032 Macro PS2_WATCHDOG_EN SHALL control the frame watchdog.
REQ-033 With PS2_WATCHDOG_EN defined: a counter SHALL clear on each falling edge; when the FSM is not IDLE and the counter reaches CLK_HZ/1_000_000*TIMEOUT_US, the FSM SHALL return to IDLE, discard the byte and pulse FRAME_ERR once.
REQ-034 Without PS2_WATCHDOG_EN: no counter SHALL be instantiated, and a stalled frame SHALL wait indefinitely.

Structure
REQ-035 Package coco_kbd_pkg SHALL hold: the FSM state enum, constants BRK_PREFIX=0xF0, EXT_PREFIX=0xE0, BAT_OK=0xAA, and the (ext, code) -> (valid, row[2:0], col[2:0]) lookup function.
REQ-036 The receiver SHALL be the single sub-module ps2_rx_frame (sync, FSM, parity, watchdog), producing byte plus a byte_valid/err pulse.
REQ-037 Decode and matrix logic SHALL live in the top level.

Verification
REQ-038 Send 0x1C (A make) with COL_N=0xFD -> ROW_N=0x7E exactly 2 cycles after the stop bit; KEY_EVT pulses once.
REQ-039 Send F0 1C -> ROW_N returns to 0x7F; send E0 75 (Up) with COL_N=0xF7 -> ROW_N=0x77.
REQ-040 Send 0x1C with a bad parity bit -> FRAME_ERR pulse, matrix unchanged, ROW_N=0x7F.
REQ-041 Hold 12 (LShift) and 59 (RShift), then send F0 59 -> row 6 col 7 clear; COL_N=0x7F -> ROW_N=0x7F.
REQ-042 With PS2_WATCHDOG_EN, stop ps2_clk after 4 data bits for more than 200 us -> FRAME_ERR; a following valid 0x5A frame -> ROW_N=0x3F with COL_N=0xFE.
REQ-043 Pull COCO_RESET_N low mid-frame with A held -> ROW_N=0x7F immediately; the next full 0x1C frame decodes correctly.
